// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults, derived totals/sync boundaries and common types.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int unsigned H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Width of one colour bar in the optional test pattern (8 bars across 640 pixels).
  localparam int unsigned BAR_WIDTH = 80;

  typedef logic [CNT_W-1:0] count_t;
  typedef logic [2:0]       rgb_t;

  function automatic count_t wrap_inc(input count_t value, input count_t last);
    return (value == last) ? '0 : value + count_t'(1);
  endfunction

endpackage

// File: rtl/vga_bar_pattern.sv
// Eight-bar vertical colour pattern: colour = floor(h/BAR_WIDTH) via a compare chain.
// Only compiled when VGA_TEST_PATTERN_EN is defined, the only build that instantiates it.
`ifdef VGA_TEST_PATTERN_EN
module vga_bar_pattern
  import vga_pkg::*;
#(
  parameter int unsigned BAR_W = BAR_WIDTH
) (
  input  logic [9:0] h_count,
  output logic [2:0] colour
);

  localparam count_t EDGE1 = count_t'(1 * BAR_W);
  localparam count_t EDGE2 = count_t'(2 * BAR_W);
  localparam count_t EDGE3 = count_t'(3 * BAR_W);
  localparam count_t EDGE4 = count_t'(4 * BAR_W);
  localparam count_t EDGE5 = count_t'(5 * BAR_W);
  localparam count_t EDGE6 = count_t'(6 * BAR_W);
  localparam count_t EDGE7 = count_t'(7 * BAR_W);

  // Anything past the seventh edge is bar 7; blanking beyond the visible area is done by the caller.
  always_comb begin
    colour = 3'd7;
    if (h_count < EDGE1)      colour = 3'd0;
    else if (h_count < EDGE2) colour = 3'd1;
    else if (h_count < EDGE3) colour = 3'd2;
    else if (h_count < EDGE4) colour = 3'd3;
    else if (h_count < EDGE5) colour = 3'd4;
    else if (h_count < EDGE6) colour = 3'd5;
    else if (h_count < EDGE7) colour = 3'd6;
  end

endmodule
`endif

// File: rtl/vga_sync_gen.sv
// VGA sync generator: live pixel counters plus one-cycle-registered sync/blank/colour outputs.
// Define VGA_TEST_PATTERN_EN to replace pixel_rgb with an internal vertical bar pattern.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [2:0] pixel_rgb,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [2:0] RGB,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam count_t H_LAST       = count_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam count_t V_LAST       = count_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam count_t H_VIS_END    = count_t'(H_VISIBLE);
  localparam count_t V_VIS_END    = count_t'(V_VISIBLE);
  localparam count_t H_SYNC_START = count_t'(H_VISIBLE + H_FRONT);
  localparam count_t H_SYNC_END   = count_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam count_t V_SYNC_START = count_t'(V_VISIBLE + V_FRONT);
  localparam count_t V_SYNC_END   = count_t'(V_VISIBLE + V_FRONT + V_SYNC);

  count_t h_count;
  count_t v_count;
  rgb_t   colour;
  logic   h_sync_zone;
  logic   v_sync_zone;
  logic   visible;

  // Line advances only as the pixel counter wraps, so both wrap together into (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= wrap_inc(h_count, H_LAST);
      if (h_count == H_LAST) begin
        v_count <= wrap_inc(v_count, V_LAST);
      end
    end
  end

  assign pixel_x = h_count;
  assign pixel_y = v_count;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] unused_pixel_rgb;
  assign unused_pixel_rgb = pixel_rgb;

  vga_bar_pattern u_bar_pattern (
    .h_count (h_count),
    .colour  (colour)
  );
`else
  assign colour = pixel_rgb;
`endif

  always_comb begin
    h_sync_zone = 1'b0;
    v_sync_zone = 1'b0;
    visible     = 1'b0;
    if ((h_count >= H_SYNC_START) && (h_count < H_SYNC_END)) h_sync_zone = 1'b1;
    if ((v_count >= V_SYNC_START) && (v_count < V_SYNC_END)) v_sync_zone = 1'b1;
    if ((h_count < H_VIS_END) && (v_count < V_VIS_END))      visible     = 1'b1;
  end

  // All timing outputs come from the same register stage so they stay mutually aligned.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      RGB         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~h_sync_zone;
      vsync       <= ~v_sync_zone;
      video_on    <= visible;
      RGB         <= visible ? colour : '0;
      frame_start <= (h_count == '0) && (v_count == '0);
    end
  end

endmodule
